// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch definitions: pc_src encoding, fetch FSM states, NOP word.
// S_TRAP is present only when FETCH_MISALIGN_TRAP_EN is defined.
package rv32i_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JALR   = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
    ,S_TRAP = 2'd3
`endif
  } fetch_state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selection (sequential / pc-relative / JALR).
// Optional macro: FETCH_MISALIGN_TRAP_EN keeps bit 1 so the fetch unit can trap on it.
module pc_next
  import rv32i_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  output logic [31:0] next_pc
);

  logic [31:0] target;

  always_comb begin
    target = pc + 32'd4;
    case (pc_src)
      PC_BRANCH: target = pc + imm_ext;
      PC_JALR:   target = alu_result & ~32'h1;
      default:   target = pc + 32'd4;
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    next_pc = target;
`else
    next_pc = {target[31:2], 2'b00};
`endif
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request, wait for data, hold until retired.
// Optional macro: FETCH_MISALIGN_TRAP_EN adds the sticky misalign flag and S_TRAP.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result
`ifdef FETCH_MISALIGN_TRAP_EN
  ,output logic       misalign
`endif
);

  fetch_state_e state;
  logic [31:0]  next_pc;

  pc_next u_pc_next (
    .pc         (pc),
    .pc_src     (pc_src),
    .imm_ext    (imm_ext),
    .alu_result (alu_result),
    .next_pc    (next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      instr <= NOP;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
    end else begin
      case (state)
        S_REQ: if (imem_gnt) state <= S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            instr <= imem_rdata;
            state <= S_VALID;
          end
        end
        S_VALID: begin
          if (instr_ready) begin
            pc <= next_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
            // The faulting target is still loaded into pc so it is visible to the trap handler.
            if (next_pc[1]) begin
              misalign <= 1'b1;
              state    <= S_TRAP;
            end else begin
              state <= S_REQ;
            end
`else
            state <= S_REQ;
`endif
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        S_TRAP: state <= S_TRAP;
`endif
        default: state <= S_REQ;
      endcase
    end
  end

  always_comb begin
    imem_req    = (state == S_REQ);
    instr_valid = (state == S_VALID);
    imem_addr   = pc;
    pc_plus4    = pc + 32'd4;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a one-cycle-latency memory model.
// Optional macro: FETCH_MISALIGN_TRAP_EN selects the trap-path expectations.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  pc_src;
  logic [31:0] imm_ext;
  logic [31:0] alu_result;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  logic        gnt_en;
  logic        stale_rv;
  logic        pend;
  logic [31:0] lat_addr;
  int          hs_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_pc;
  logic [31:0] snap_instr;
  int          hs_before;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_src      (pc_src),
    .imm_ext     (imm_ext),
    .alu_result  (alu_result)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,.misalign   (misalign)
`endif
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory: grants when enabled, returns data one cycle after the grant; reset with the DUT.
  assign imem_gnt    = gnt_en;
  assign imem_rvalid = pend | stale_rv;
  assign imem_rdata  = stale_rv ? 32'hDEAD_BEEF : word(lat_addr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= 1'b0;
      lat_addr <= 32'h0;
    end else begin
      pend <= imem_req & imem_gnt;
      if (imem_req && imem_gnt) lat_addr <= imem_addr;
    end
  end

  always @(posedge clk) if (!rst && imem_req && imem_gnt) hs_cnt <= hs_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) break;
      @(negedge clk);
    end
    check_eq({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    check_eq({tag, "_pc"}, pc, exp_pc);
    check_eq({tag, "_instr"}, instr, word(exp_pc));
  endtask

  task automatic retire(input string tag, input logic [1:0] src, input logic [31:0] imm,
                        input logic [31:0] alu, input logic [31:0] exp_addr);
    wait_valid(tag);
    instr_ready = 1'b1;
    pc_src      = src;
    imm_ext     = imm;
    alu_result  = alu;
    @(negedge clk);
    instr_ready = 1'b0;
    pc_src      = 2'd1;
    imm_ext     = 32'h0BAD_0000;
    alu_result  = 32'h0BAD_0001;
    check_eq({tag, "_addr"}, imem_addr, exp_addr);
    check_eq({tag, "_req"}, {31'b0, imem_req}, 32'd1);
    exp_pc = exp_addr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; instr_ready = 1'b0; pc_src = 2'd0; imm_ext = '0; alu_result = '0;
    gnt_en = 1'b1; stale_rv = 1'b0; exp_pc = 32'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("rst_instr", instr, 32'h0000_0013);
    check_eq("rst_pc", pc, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check_eq("rst_misalign", {31'b0, misalign}, 32'd0);
`endif
    rst = 1'b0;
    check_eq("c1_req", {31'b0, imem_req}, 32'd1);
    check_eq("c1_addr", imem_addr, 32'h0);
    @(negedge clk);
    check_eq("c2_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("c2_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    check_eq("c3_valid", {31'b0, instr_valid}, 32'd1);
    check_eq("c3_plus4", pc_plus4, 32'h4);

    retire("seq1", 2'd0, '0, '0, 32'h4);
    retire("seq2", 2'd0, '0, '0, 32'h8);
    retire("seq3", 2'd0, '0, '0, 32'hC);
    retire("seq4", 2'd0, '0, '0, 32'h10);
    retire("jtop", 2'd2, '0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    retire("wrap", 2'd0, '0, '0, 32'h0);
    retire("rsvd", 2'd3, 32'h100, 32'h300, 32'h4);
    retire("j100", 2'd2, '0, 32'h100, 32'h100);
    retire("br", 2'd1, 32'hFFFF_FFF0, '0, 32'hF0);
    retire("jalr", 2'd2, '0, 32'h205, 32'h204);

    wait_valid("hold");
    snap_instr = instr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("hold_valid", {31'b0, instr_valid}, 32'd1);
      check_eq("hold_instr", instr, snap_instr);
      check_eq("hold_pc", pc, 32'h204);
      check_eq("hold_plus4", pc_plus4, 32'h208);
    end
    hs_before = hs_cnt;
    gnt_en = 1'b0;
    retire("nogn", 2'd0, '0, '0, 32'h208);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("nogn_req", {31'b0, imem_req}, 32'd1);
      check_eq("nogn_addr", imem_addr, 32'h208);
      check_eq("nogn_hs", hs_cnt, hs_before);
    end
    gnt_en = 1'b1;
    wait_valid("gnt");
    check_eq("gnt_hs", hs_cnt, hs_before + 1);

    retire("pre_rst", 2'd0, '0, '0, 32'h20C);
    @(negedge clk);
    check_eq("wait_req", {31'b0, imem_req}, 32'd0);
    rst = 1'b1;
    gnt_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    stale_rv = 1'b1;
    check_eq("ab_pc", pc, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("stale_valid", {31'b0, instr_valid}, 32'd0);
      check_eq("stale_instr", instr, 32'h0000_0013);
      check_eq("stale_req", {31'b0, imem_req}, 32'd1);
    end
    stale_rv = 1'b0;
    gnt_en = 1'b1;
    exp_pc = 32'h0;
    wait_valid("fresh");

`ifdef FETCH_MISALIGN_TRAP_EN
    instr_ready = 1'b1; pc_src = 2'd1; imm_ext = 32'h6;
    @(negedge clk);
    instr_ready = 1'b0; pc_src = 2'd0; imm_ext = '0;
    for (int i = 0; i < 4; i++) begin
      check_eq("trap_mis", {31'b0, misalign}, 32'd1);
      check_eq("trap_req", {31'b0, imem_req}, 32'd0);
      check_eq("trap_valid", {31'b0, instr_valid}, 32'd0);
      check_eq("trap_pc", pc, 32'h6);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("trap_clr", {31'b0, misalign}, 32'd0);
    check_eq("trap_rpc", pc, 32'h0);
    exp_pc = 32'h0;
    wait_valid("post_trap");
`else
    retire("mis", 2'd1, 32'h6, '0, 32'h4);
    wait_valid("mis_fetch");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
